// File: rtl/cache_mem_pkg.sv
// rtl/cache_mem_pkg.sv - shared types and geometry helpers for cache_mem_interface
//
// Purpose: holds the memory-interface state enum and the derived geometry
// helpers (beats per line, bytes per beat, line offset width).
// Ports: none (package).

package cache_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_BEAT,
    RD_REQ,
    RD_WAIT,
    DONE
  } mem_if_state_t;

  // Number of bus beats needed to move one cache line.
  function automatic int beats(input int line_width, input int bus_width);
    return line_width / bus_width;
  endfunction

  // Byte stride between consecutive beat addresses.
  function automatic int beat_bytes(input int bus_width);
    return bus_width / 8;
  endfunction

  // Number of low address bits that select a byte within a line.
  function automatic int line_offset_bits(input int line_width);
    return $clog2(line_width / 8);
  endfunction

endpackage

// File: rtl/cache_mem_interface.sv
// rtl/cache_mem_interface.sv - line-to-beat bridge between cache_controller and the memory bus
//
// Purpose: launches a line refill or write-back on request, walks the line in
// BUS_WIDTH beats over a valid/ready request bus, assembles read data into
// refill_line, and pulses ready_mem for one cycle when the line is done.
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   read_en_mem, write_en_mem  line-level requests from the cache controller
//   line_addr, wb_line         line byte address and write-back data (sampled at launch)
//   refill_line, ready_mem     assembled refill data, one-cycle completion pulse
//   mem_req_valid/ready        beat request handshake
//   mem_we, mem_addr, mem_wdata  beat request payload
//   mem_rvalid, mem_rdata      read beat return

module cache_mem_interface
  import cache_mem_pkg::*;
#(
  parameter int LINE_WIDTH = 128,
  parameter int BUS_WIDTH  = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read_en_mem,
  input  logic                  write_en_mem,
  input  logic [ADDR_WIDTH-1:0] line_addr,
  input  logic [LINE_WIDTH-1:0] wb_line,
  output logic [LINE_WIDTH-1:0] refill_line,
  output logic                  ready_mem,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [BUS_WIDTH-1:0]  mem_wdata,
  input  logic                  mem_rvalid,
  input  logic [BUS_WIDTH-1:0]  mem_rdata
);

  localparam int BEATS            = beats(LINE_WIDTH, BUS_WIDTH);
  localparam int BEAT_BYTES       = beat_bytes(BUS_WIDTH);
  localparam int LINE_OFFSET_BITS = line_offset_bits(LINE_WIDTH);
  localparam int BEAT_W           = $clog2(BEATS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  mem_if_state_t         state_q, state_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [LINE_WIDTH-1:0] wb_q, wb_d;
  logic [LINE_WIDTH-1:0] refill_q, refill_d;
  logic                  rd_armed_q, rd_armed_d;
  logic                  wr_armed_q, wr_armed_d;
  logic [ADDR_WIDTH-1:0] launch_base;

  assign launch_base = {line_addr[ADDR_WIDTH-1:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};

  // Payload is a pure function of registered state, so it is stable while a
  // request waits for mem_req_ready.
  assign mem_addr    = base_q + ADDR_WIDTH'(beat_q) * ADDR_WIDTH'(BEAT_BYTES);
  assign mem_wdata   = wb_q[beat_q*BUS_WIDTH +: BUS_WIDTH];
  assign refill_line = refill_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      base_q     <= '0;
      wb_q       <= '0;
      refill_q   <= '0;
      rd_armed_q <= 1'b1;
      wr_armed_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      base_q     <= base_d;
      wb_q       <= wb_d;
      refill_q   <= refill_d;
      rd_armed_q <= rd_armed_d;
      wr_armed_q <= wr_armed_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    base_d        = base_q;
    wb_d          = wb_q;
    refill_d      = refill_q;
    // An enable must be seen low once before it may launch again, so an
    // enable still held just after ready_mem does not start a second transfer.
    rd_armed_d    = rd_armed_q | ~read_en_mem;
    wr_armed_d    = wr_armed_q | ~write_en_mem;
    ready_mem     = 1'b0;
    mem_req_valid = 1'b0;
    mem_we        = 1'b0;

    case (state_q)
      IDLE: begin
        // Write-back goes first so a dirty victim leaves before its
        // replacement is allocated.
        if (write_en_mem && wr_armed_q) begin
          state_d    = WR_BEAT;
          wr_armed_d = 1'b0;
          base_d     = launch_base;
          wb_d       = wb_line;
          beat_d     = '0;
        end else if (read_en_mem && rd_armed_q) begin
          state_d    = RD_REQ;
          rd_armed_d = 1'b0;
          base_d     = launch_base;
          wb_d       = wb_line;
          beat_d     = '0;
        end
      end
      WR_BEAT: begin
        mem_req_valid = 1'b1;
        mem_we        = 1'b1;
        if (mem_req_ready) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) state_d = DONE;
        end
      end
      RD_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (mem_rvalid) begin
          refill_d[beat_q*BUS_WIDTH +: BUS_WIDTH] = mem_rdata;
          beat_d  = beat_q + 1'b1;
          state_d = (beat_q == LAST_BEAT) ? DONE : RD_REQ;
        end
      end
      DONE: begin
        ready_mem = 1'b1;
        beat_d    = '0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
